multdiv_alu_seq: RTL and testbench
==================================

# multdiv_alu_seq

- Multi-cycle signed 32-bit multiply/divide sequencer; it has no arithmetic of its own.
- Every add, subtract and shift goes through the shared ALU's operand, opcode, shift-amount, result and overflow ports.
- Sits beside the execute stage; the pipeline stalls while `busy` is high and consumes the result on `data_resultRDY`.

## Interface
- No parameters; data width fixed at 32, iteration count fixed at 32.
- `clock` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-low; one clock, reset is asynchronous and active-low.
- `ctrl_MULT` in 1: start signed multiply; sampled only in IDLE.
- `ctrl_DIV` in 1: start signed divide; sampled only in IDLE.
- `data_operandA` in 32: multiplicand / dividend, sampled at start.
- `data_operandB` in 32: multiplier / divisor, sampled at start.
- `data_result` out 32: low 32 bits of product, or quotient truncated toward zero; holds until next DONE.
- `data_exception` out 1: valid with `data_resultRDY`; holds with `data_result`.
- `data_resultRDY` out 1: one-cycle pulse in DONE.
- `busy` out 1: high in every state except IDLE.
- `alu_opA`, `alu_opB` out 32: ALU operands.
- `alu_opcode` out 5: 0 ADD, 1 SUB, 4 SLL.
- `alu_shamt` out 5: ALU shift amount.
- `alu_result` in 32: combinational ALU result for the current cycle.
- `alu_overflow` in 1: ALU signed overflow; unused (carry/borrow computed locally).

## Operation
- States: IDLE, ABS_A, ABS_B, MUL_SHL, MUL_ADD, DIV_SUB, SIGN, DONE.
- IDLE: ALU outputs 0 / ADD.
  - `ctrl_MULT` → latch operands and `neg = A[31]^B[31]`, go to ABS_A. `ctrl_MULT` wins if both starts are high.
  - `ctrl_DIV` with B==0 → DONE with result 0, exception 1.
  - `ctrl_DIV` otherwise → ABS_A.
  - Starts while busy are ignored.
- ABS_A / ABS_B: drive SUB(0, x); latch `alu_result` as magnitude if x[31], else x unchanged. This cycle is always spent.
- Multiply, acc=0, for i=31..0:
  - MUL_SHL: SLL(acc, 1); carry = acc[31].
  - MUL_ADD: ADD(acc, |B|[i] ? |A| : 0); carry = (a31&b31) | ((a31|b31)&~r31).
  - Any carry sets sticky `ovf`. After i=0 go to SIGN.
- Divide, restoring, rem=0, q=|A|, 32 DIV_SUB cycles:
  - t = {rem[30:0], q[31]}; drive SUB(t, |B|).
  - borrow = (~t31&b31) | (~(t31^b31)&r31).
  - No borrow → rem = result, shift 1 into q; else rem = t, shift 0 into q.
- SIGN: drive SUB(0, mag) if `neg`, else pass mag. Exception set when:
  - mul: `ovf`, or mag[31] & (~neg | mag != 0x80000000);
  - div: mag[31] & ~neg (the −2^31 / −1 case).
- DONE: register result and exception, pulse `data_resultRDY`, return to IDLE.
- Reset, any state including mid-operation:
  - state IDLE, all outputs 0, no RDY pulse; partial result discarded.

## Timing
- Start seen at edge t0; ABS_A is t1.
- Mult: RDY high in cycle t68 (2 + 64 + SIGN + DONE).
- Div: RDY high in cycle t36.
- Div-by-zero: RDY high in cycle t1.
- New start accepted in the cycle after DONE (back-to-back allowed).
- ALU is combinational; its output is consumed in the same cycle it is driven.

## Structure
- Shared package holds:
  - ALU opcode constants (ADD=0, SUB=1, AND=2, OR=3, SLL=4, SRA=5);
  - state enum;
  - iteration-count constant (32).
- No sub-module; one state register plus a small local datapath (acc/rem, q, magnitudes, bit counter, neg, ovf).

## Test plan
- MULT 7 × −6 → result 0xFFFFFFD6, exception 0, RDY exactly 68 cycles after start, `busy` high in between.
- MULT 0x00010000 × 0x00010000 → exception 1. MULT −2^31 × 1 → 0x80000000, exception 0. MULT −2^31 × −1 → exception 1.
- DIV −100 / 7 → 0xFFFFFFF2 (−14), RDY at 36 cycles. DIV 5 / 0 → result 0, exception 1, RDY at 1 cycle. DIV −2^31 / −1 → exception 1.
- ctrl_MULT and ctrl_DIV together with 6, 3 → 18. Second start pulse mid-operation ignored: exactly one RDY.
- Reset asserted at cycle 20 of a multiply → all outputs 0 immediately, no RDY. Then DIV 9 / 2 after release → 4.
- Random signed operand pairs versus reference arithmetic; check the ALU opcode sequence every cycle.

Source files
------------

// File: rtl/multdiv_alu_seq_pkg.sv
// Shared constants and state encoding for the multiply/divide sequencer.
package multdiv_alu_seq_pkg;

   localparam logic [4:0] OP_ADD = 5'd0;
   localparam logic [4:0] OP_SUB = 5'd1;
   localparam logic [4:0] OP_AND = 5'd2;
   localparam logic [4:0] OP_OR  = 5'd3;
   localparam logic [4:0] OP_SLL = 5'd4;
   localparam logic [4:0] OP_SRA = 5'd5;

   localparam int ITER = 32;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ABS_A,
      S_ABS_B,
      S_MUL_SHL,
      S_MUL_ADD,
      S_DIV_SUB,
      S_SIGN,
      S_DONE
   } state_t;

endpackage

// File: rtl/multdiv_alu_seq.sv
// Signed 32-bit multiply/divide sequencer; all arithmetic is borrowed from the
// shared execute-stage ALU through the alu_* ports.
//
// state     | meaning
// IDLE      | waiting for ctrl_MULT / ctrl_DIV, ALU driven with ADD(0,0)
// ABS_A     | magnitude of operand A via SUB(0, A)
// ABS_B     | magnitude of operand B via SUB(0, B)
// MUL_SHL   | acc <<= 1, carry out feeds sticky overflow
// MUL_ADD   | acc += |B|[i] ? |A| : 0
// DIV_SUB   | one restoring-divide step
// SIGN      | apply result sign, register result and exception
// DONE      | result valid, data_resultRDY high for this cycle
module multdiv_alu_seq
   import multdiv_alu_seq_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        ctrl_MULT,
   input  logic        ctrl_DIV,
   input  logic [31:0] data_operandA,
   input  logic [31:0] data_operandB,
   output logic [31:0] data_result,
   output logic        data_exception,
   output logic        data_resultRDY,
   output logic        busy,
   output logic [31:0] alu_opA,
   output logic [31:0] alu_opB,
   output logic [4:0]  alu_opcode,
   output logic [4:0]  alu_shamt,
   input  logic [31:0] alu_result,
   input  logic        alu_overflow
);

   state_t      state;
   logic [31:0] a_mag;
   logic [31:0] b_mag;
   logic [31:0] acc;
   logic [4:0]  cnt;
   logic        neg;
   logic        ovf;
   logic        is_div;

   logic [31:0] trial;
   logic [31:0] mag;
   logic        add_carry;
   logic        sub_borrow;
   logic        mul_exc;
   logic        div_exc;
   logic        alu_overflow_unused;

   // Carry and borrow are rebuilt from operand/result sign bits rather than alu_overflow.
   assign alu_overflow_unused = alu_overflow;

   // For divide, a_mag doubles as the quotient shift register.
   assign trial      = {acc[30:0], a_mag[31]};
   assign mag        = is_div ? a_mag : acc;
   assign add_carry  = (alu_opA[31] & alu_opB[31]) | ((alu_opA[31] | alu_opB[31]) & ~alu_result[31]);
   assign sub_borrow = (~trial[31] & b_mag[31]) | (~(trial[31] ^ b_mag[31]) & alu_result[31]);
   assign mul_exc    = ovf | (mag[31] & (~neg | (mag != 32'h8000_0000)));
   assign div_exc    = mag[31] & ~neg;
   assign busy       = (state != S_IDLE);

   always_comb begin
      alu_opA    = '0;
      alu_opB    = '0;
      alu_opcode = OP_ADD;
      alu_shamt  = '0;
      case (state)
         S_ABS_A: begin
            alu_opcode = OP_SUB;
            alu_opB    = a_mag;
         end
         S_ABS_B: begin
            alu_opcode = OP_SUB;
            alu_opB    = b_mag;
         end
         S_MUL_SHL: begin
            alu_opcode = OP_SLL;
            alu_opA    = acc;
            alu_shamt  = 5'd1;
         end
         S_MUL_ADD: begin
            alu_opA = acc;
            alu_opB = b_mag[cnt] ? a_mag : '0;
         end
         S_DIV_SUB: begin
            alu_opcode = OP_SUB;
            alu_opA    = trial;
            alu_opB    = b_mag;
         end
         S_SIGN: begin
            alu_opcode = neg ? OP_SUB : OP_ADD;
            alu_opB    = mag;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state          <= S_IDLE;
         a_mag          <= '0;
         b_mag          <= '0;
         acc            <= '0;
         cnt            <= '0;
         neg            <= 1'b0;
         ovf            <= 1'b0;
         is_div         <= 1'b0;
         data_result    <= '0;
         data_exception <= 1'b0;
         data_resultRDY <= 1'b0;
      end else begin
         data_resultRDY <= 1'b0;
         case (state)
            S_IDLE: begin
               if (ctrl_MULT || ctrl_DIV) begin
                  a_mag  <= data_operandA;
                  b_mag  <= data_operandB;
                  neg    <= data_operandA[31] ^ data_operandB[31];
                  ovf    <= 1'b0;
                  is_div <= ~ctrl_MULT;
                  if (!ctrl_MULT && (data_operandB == '0)) begin
                     data_result    <= '0;
                     data_exception <= 1'b1;
                     data_resultRDY <= 1'b1;
                     state          <= S_DONE;
                  end else begin
                     state <= S_ABS_A;
                  end
               end
            end
            S_ABS_A: begin
               if (a_mag[31]) a_mag <= alu_result;
               state <= S_ABS_B;
            end
            S_ABS_B: begin
               if (b_mag[31]) b_mag <= alu_result;
               acc   <= '0;
               cnt   <= 5'(ITER - 1);
               state <= is_div ? S_DIV_SUB : S_MUL_SHL;
            end
            S_MUL_SHL: begin
               acc <= alu_result;
               if (acc[31]) ovf <= 1'b1;
               state <= S_MUL_ADD;
            end
            S_MUL_ADD: begin
               acc <= alu_result;
               if (add_carry) ovf <= 1'b1;
               if (cnt == '0) begin
                  state <= S_SIGN;
               end else begin
                  cnt   <= cnt - 5'd1;
                  state <= S_MUL_SHL;
               end
            end
            S_DIV_SUB: begin
               if (!sub_borrow) begin
                  acc   <= alu_result;
                  a_mag <= {a_mag[30:0], 1'b1};
               end else begin
                  acc   <= trial;
                  a_mag <= {a_mag[30:0], 1'b0};
               end
               if (cnt == '0) state <= S_SIGN;
               else           cnt   <= cnt - 5'd1;
            end
            S_SIGN: begin
               data_result    <= alu_result;
               data_exception <= is_div ? div_exc : mul_exc;
               data_resultRDY <= 1'b1;
               state          <= S_DONE;
            end
            S_DONE: state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_multdiv_alu_seq.sv
// Bench for multdiv_alu_seq: combinational ALU model, arithmetic reference
// model and a per-cycle compare of busy/RDY/opcode/result.
module tb_multdiv_alu_seq;

   logic        clock;
   logic        reset;
   logic        ctrl_MULT;
   logic        ctrl_DIV;
   logic [31:0] data_operandA;
   logic [31:0] data_operandB;
   logic [31:0] data_result;
   logic        data_exception;
   logic        data_resultRDY;
   logic        busy;
   logic [31:0] alu_opA;
   logic [31:0] alu_opB;
   logic [4:0]  alu_opcode;
   logic [4:0]  alu_shamt;
   logic [31:0] alu_result;
   logic        alu_overflow;

   multdiv_alu_seq dut (
      .clock(clock), .reset(reset), .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
      .data_operandA(data_operandA), .data_operandB(data_operandB),
      .data_result(data_result), .data_exception(data_exception),
      .data_resultRDY(data_resultRDY), .busy(busy),
      .alu_opA(alu_opA), .alu_opB(alu_opB), .alu_opcode(alu_opcode),
      .alu_shamt(alu_shamt), .alu_result(alu_result), .alu_overflow(alu_overflow)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always_comb begin
      alu_result   = '0;
      alu_overflow = 1'b0;
      case (alu_opcode)
         5'd0: begin
            alu_result   = alu_opA + alu_opB;
            alu_overflow = (alu_opA[31] == alu_opB[31]) && (alu_result[31] != alu_opA[31]);
         end
         5'd1: begin
            alu_result   = alu_opA - alu_opB;
            alu_overflow = (alu_opA[31] != alu_opB[31]) && (alu_result[31] != alu_opA[31]);
         end
         5'd2: alu_result = alu_opA & alu_opB;
         5'd3: alu_result = alu_opA | alu_opB;
         5'd4: alu_result = alu_opA << alu_shamt;
         5'd5: alu_result = $signed(alu_opA) >>> alu_shamt;
         default: ;
      endcase
   end

   int checks = 0;
   int failures = 0;

   bit          active = 0;
   int          k = 0;
   int          lat = 0;
   int          kind = 0;
   bit          exp_neg = 0;
   logic [31:0] exp_res = '0;
   logic        exp_exc = 0;
   logic [31:0] held_res = '0;
   logic        held_exc = 0;
   logic [31:0] last_res = '0;
   logic        last_exc = 0;
   int          rdy_count = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h expected=0x%08h t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference: plain 64-bit signed arithmetic.
   task automatic model(input bit is_mul, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r, output logic e);
      longint sa, sb, p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (is_mul) begin
         p = sa * sb;
         r = p[31:0];
         e = (p != longint'($signed(r)));
      end else if (b == '0) begin
         r = '0;
         e = 1'b1;
      end else begin
         p = sa / sb;
         r = p[31:0];
         e = (p > 64'sd2147483647);
      end
   endtask

   // kind 0 = multiply, 1 = divide, 2 = divide by zero; kk = cycles since start edge.
   function automatic logic [4:0] exp_op(input int kd, input int kk, input bit ng);
      if (kd == 2) return 5'd0;
      if (kk <= 2) return 5'd1;
      if (kd == 0) begin
         if (kk <= 66) return (kk % 2 == 1) ? 5'd4 : 5'd0;
         if (kk == 67) return ng ? 5'd1 : 5'd0;
         return 5'd0;
      end
      if (kk <= 34) return 5'd1;
      if (kk == 35) return ng ? 5'd1 : 5'd0;
      return 5'd0;
   endfunction

   always @(negedge clock) begin
      if (data_resultRDY) rdy_count++;
      if (!reset) begin
         check("rst_busy", 32'(busy), 32'd0);
         check("rst_rdy", 32'(data_resultRDY), 32'd0);
         check("rst_result", data_result, 32'd0);
         check("rst_exc", 32'(data_exception), 32'd0);
         check("rst_opcode", 32'(alu_opcode), 32'd0);
         check("rst_opA", alu_opA, 32'd0);
         active   = 0;
         k        = 0;
         held_res = '0;
         held_exc = 0;
      end else if (!active || k == 0) begin
         check("idle_busy", 32'(busy), 32'd0);
         check("idle_rdy", 32'(data_resultRDY), 32'd0);
         check("idle_opcode", 32'(alu_opcode), 32'd0);
         check("hold_result", data_result, held_res);
         check("hold_exc", 32'(data_exception), 32'(held_exc));
         if (active) k = 1;
      end else begin
         check("run_busy", 32'(busy), 32'd1);
         check("run_rdy", 32'(data_resultRDY), 32'(k == lat));
         check("run_opcode", 32'(alu_opcode), 32'(exp_op(kind, k, exp_neg)));
         if (alu_opcode == 5'd4) check("sll_shamt", 32'(alu_shamt), 32'd1);
         if (k == lat) begin
            check("result", data_result, exp_res);
            check("exception", 32'(data_exception), 32'(exp_exc));
            last_res = data_result;
            last_exc = data_exception;
            held_res = exp_res;
            held_exc = exp_exc;
            active   = 0;
            k        = 0;
         end else begin
            k = k + 1;
         end
      end
   end

   task automatic start_op(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b);
      @(posedge clock);
      #1;
      ctrl_MULT     = m;
      ctrl_DIV      = d;
      data_operandA = a;
      data_operandB = b;
      model(m, a, b, exp_res, exp_exc);
      exp_neg = a[31] ^ b[31];
      kind    = m ? 0 : ((b == '0) ? 2 : 1);
      lat     = (kind == 0) ? 68 : ((kind == 1) ? 36 : 1);
      k       = 0;
      active  = 1;
      @(posedge clock);
      #1;
      ctrl_MULT     = 1'b0;
      ctrl_DIV      = 1'b0;
      data_operandA = $urandom;
      data_operandB = $urandom;
   endtask

   task automatic wait_done();
      int g;
      g = 0;
      while (active && g < 200) begin
         @(negedge clock);
         #1;
         g++;
      end
      if (active) begin
         checks++;
         failures++;
         $display("FAIL rdy_timeout waited=%0d cycles required RDY within %0d", g, lat);
         active = 0;
      end
   endtask

   task automatic run(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b);
      start_op(m, d, a, b);
      wait_done();
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 6))
         0:       return 32'd0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3, 4:    return 32'($urandom_range(0, 400)) - 32'd200;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int rc;
      reset         = 1'b1;
      ctrl_MULT     = 1'b0;
      ctrl_DIV      = 1'b0;
      data_operandA = '0;
      data_operandB = '0;
      #2 reset = 1'b0;
      repeat (3) @(posedge clock);
      #1 reset = 1'b1;

      run(1, 0, 32'd7, -32'd6);
      check("pin_mul_7x-6", last_res, 32'hFFFF_FFD6);
      check("pin_mul_7x-6_exc", 32'(last_exc), 32'd0);
      run(1, 0, 32'h0001_0000, 32'h0001_0000);
      check("pin_mul_2^32_exc", 32'(last_exc), 32'd1);
      run(1, 0, 32'h8000_0000, 32'd1);
      check("pin_mul_min_x1", last_res, 32'h8000_0000);
      check("pin_mul_min_x1_exc", 32'(last_exc), 32'd0);
      run(1, 0, 32'h8000_0000, 32'hFFFF_FFFF);
      check("pin_mul_min_x-1_exc", 32'(last_exc), 32'd1);
      run(0, 1, -32'd100, 32'd7);
      check("pin_div_-100/7", last_res, 32'hFFFF_FFF2);
      run(0, 1, 32'd5, 32'd0);
      check("pin_div_by0", last_res, 32'd0);
      check("pin_div_by0_exc", 32'(last_exc), 32'd1);
      run(0, 1, 32'h8000_0000, 32'hFFFF_FFFF);
      check("pin_div_min/-1_exc", 32'(last_exc), 32'd1);
      run(1, 1, 32'd6, 32'd3);
      check("pin_both_starts", last_res, 32'd18);

      rc = rdy_count;
      start_op(1, 0, 32'd123, -32'd45);
      repeat (9) @(posedge clock);
      #1;
      ctrl_MULT = 1'b1;
      ctrl_DIV  = 1'b1;
      data_operandA = 32'd1;
      data_operandB = 32'd0;
      @(posedge clock);
      #1;
      ctrl_MULT = 1'b0;
      ctrl_DIV  = 1'b0;
      wait_done();
      repeat (3) @(posedge clock);
      check("pin_mid_start_result", last_res, 32'hFFFF_EA61);
      check("single_rdy_pulse", 32'(rdy_count - rc), 32'd1);

      rc = rdy_count;
      start_op(1, 0, 32'd1234, 32'd5678);
      repeat (19) @(posedge clock);
      #1;
      reset = 1'b0;
      #1;
      check("async_rst_busy", 32'(busy), 32'd0);
      check("async_rst_result", data_result, 32'd0);
      check("async_rst_opcode", 32'(alu_opcode), 32'd0);
      repeat (2) @(posedge clock);
      #1 reset = 1'b1;
      repeat (70) @(posedge clock);
      check("no_rdy_after_reset", 32'(rdy_count - rc), 32'd0);
      run(0, 1, 32'd9, 32'd2);
      check("pin_div_9/2", last_res, 32'd4);

      for (int i = 0; i < 40; i++) begin
         logic m, d;
         m = 1'($urandom_range(0, 1));
         d = m ? 1'($urandom_range(0, 1)) : 1'b1;
         repeat ($urandom_range(0, 2)) @(posedge clock);
         run(m, d, pick(), pick());
      end

      repeat (3) @(posedge clock);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL global_timeout reached t=%0t", $time);
      $fatal(1, "bench timeout");
   end

endmodule
